decoder_scan_sequencer: RTL and testbench
=========================================

// Module: decoder_scan_sequencer
// PURPOSE
//  Drives the a/b/c select inputs of the 3:8 decoder stage that sits directly downstream.
//  Steps the 3-bit select through 0..7, holding each value for a programmable dwell time.
//  Advances only when the consumer acknowledges through a valid/ready handshake.
//  Runs either one pass or continuously; supports abort and direct address load.
// PARAMETERS
//  DWELL_W  8  width of the dwell input and the dwell counter
// PORTS
//  clk        in   1        single clock; all state updates on the rising edge
//  rst        in   1        synchronous, active-high reset
//  start      in   1        begins a scan at address 0; ignored while busy=1
//  stop       in   1        aborts the scan and returns to IDLE
//  cont       in   1        sampled at start: 1=continuous wrap, 0=single pass
//  dwell      in   DWELL_W  cycles per address; sampled at each address entry; 0 is treated as 1
//  load       in   1        forces the select to load_sel in DWELL/HOLD
//  load_sel   in   3        address used by load
//  sel_ready  in   1        consumer ready; an advance requires sel_ready=1
//  a          out  1        select MSB (bit 2) to the decoder
//  b          out  1        select bit 1
//  c          out  1        select LSB (bit 0)
//  sel_valid  out  1        a/b/c are a live scan address
//  busy       out  1        state is not IDLE
//  wrap       out  1        one-cycle pulse on the advance out of address 7
//  done       out  1        one-cycle pulse when a single pass completes
// BEHAVIOUR
//  - Reset (rst=1 at a clock edge): state IDLE; a=b=c=0; sel_valid=0; busy=0; wrap=0;
//    done=0; dwell counter=0. Reset has priority over every other input.
//  - Priority order: rst > stop > load > advance > start.
//  - States:
//    IDLE: start=1 gives sel=0, cnt=max(dwell,1), latches cont, and moves to DWELL.
//      sel_valid and busy rise on the cycle after start.
//    DWELL: cnt decrements each cycle. When cnt==1, one of two things happens:
//      sel_ready=1 gives an advance; sel_ready=0 moves to HOLD.
//    HOLD: sel_valid stays 1 and the select is frozen. Advance on the first cycle with sel_ready=1.
//  - Advance:
//    sel<7: sel=sel+1; cnt reloads from dwell; state becomes DWELL.
//    sel==7 and cont=1: sel=0; wrap=1 for one cycle; state stays DWELL.
//    sel==7 and cont=0: wrap=1 and done=1 in the same cycle; state becomes IDLE;
//      sel_valid=0 and busy=0; a/b/c hold 3'b111.
//  - stop in DWELL/HOLD: next cycle is IDLE with sel_valid=0 and busy=0.
//    No done or wrap pulse; a/b/c hold their value. stop in IDLE has no effect.
//  - load in DWELL/HOLD: sel=load_sel and cnt reloads from dwell.
//    The state is unchanged, so HOLD returns to DWELL. Ignored in IDLE.
//  - load coincident with an advance: load wins and no wrap/done is produced.
//  - start while busy: ignored. start coincident with stop in IDLE: stop wins, so the block stays IDLE.
//  - Changing cont mid-scan has no effect until the next start.
//  - a/b/c, sel_valid, wrap and done are registered outputs with no combinational paths from inputs.
// CONFIGURATION
//  SKIP_MASK_EN defined:
//    - Adds port skip_mask in 8; bit i=1 excludes address i. The mask is sampled at every address selection.
//    - Start and every advance select the next unmasked address in ascending order,
//      wrapping past 7. wrap fires whenever the selection passes through 7.
//    - Start with skip_mask=8'hFF: done pulses on the next cycle, sel_valid stays 0, state stays IDLE.
//    - load_sel is applied even if masked.
//  SKIP_MASK_EN undefined: no skip_mask port; all eight addresses are visited.
// TESTING
//  1. Reset: rst=1 for 2 cycles with start=1 -> all outputs 0 and busy=0.
//  2. Single pass, dwell=3, sel_ready=1, cont=0: start@T0 gives these responses.
//     - sel_valid=1 from T1 with abc=000.
//     - abc increments every 3 cycles.
//     - abc=111 spans T22..T24; wrap=done=1 at T25; then IDLE.
//  3. Backpressure: sel_ready=0 while abc=010 for 5 cycles.
//     - abc holds 010 in HOLD; advance to 011 one cycle after sel_ready returns to 1.
//  4. Continuous, dwell=0 (acts as 1): abc steps every cycle.
//     - abc goes 000..111,000; wrap pulses once per lap; done never asserts.
//  5. Mid-scan: load=1, load_sel=5 at abc=001 -> next abc=101.
//     - Later, stop=1 -> sel_valid=0 next cycle; no done pulse.
//  6. (SKIP_MASK_EN) skip_mask=8'b1010_1010, cont=0 -> abc sequence 000,010,100,110.
//     - done pulses on the advance out of 110; skip_mask=8'hFF -> done pulses one cycle after start.

Source files
------------

// File: rtl/decoder_scan_sequencer.sv
// Scan sequencer driving the a/b/c selects of a downstream 3:8 decoder with dwell and handshake.
// Optional SKIP_MASK_EN adds a skip_mask port that excludes addresses from the scan.
module decoder_scan_sequencer #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               load,
    input  logic [2:0]         load_sel,
    input  logic               sel_ready,
`ifdef SKIP_MASK_EN
    input  logic [7:0]         skip_mask,
`endif
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               sel_valid,
    output logic               busy,
    output logic               wrap,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DWELL,
        S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               cont_q, cont_d;
    logic               wrap_q, wrap_d;
    logic               done_q, done_d;

    logic [7:0]         mask;
    logic [DWELL_W-1:0] dwell_ld;
    logic               advance;
    logic               adv_found, adv_pass7;
    logic [2:0]         adv_sel;
    logic               st_found;
    logic [2:0]         st_sel;
    logic [3:0]         sum;

`ifdef SKIP_MASK_EN
    assign mask = skip_mask;
`else
    assign mask = '0;
`endif

    assign dwell_ld = (dwell == '0) ? DWELL_W'(1) : dwell;

    // Next unmasked address after sel_q (offset 8 revisits sel_q itself); sum[3] flags passing 7.
    always_comb begin
        adv_found = 1'b0;
        adv_sel   = sel_q;
        adv_pass7 = 1'b0;
        sum       = '0;
        for (int unsigned k = 1; k <= 8; k++) begin
            sum = {1'b0, sel_q} + 4'(k);
            if (!adv_found && !mask[sum[2:0]]) begin
                adv_found = 1'b1;
                adv_sel   = sum[2:0];
                adv_pass7 = sum[3];
            end
        end
    end

    always_comb begin
        st_found = 1'b0;
        st_sel   = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (!st_found && !mask[k]) begin
                st_found = 1'b1;
                st_sel   = 3'(k);
            end
        end
    end

    assign advance = sel_ready &&
                     ((state_q == S_HOLD) ||
                      (state_q == S_DWELL && cnt_q == DWELL_W'(1)));

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        cont_d  = cont_q;
        wrap_d  = 1'b0;
        done_d  = 1'b0;
        if (state_q == S_IDLE) begin
            if (start && !stop) begin
                cont_d = cont;
                if (st_found) begin
                    sel_d   = st_sel;
                    cnt_d   = dwell_ld;
                    state_d = S_DWELL;
                end else begin
                    done_d = 1'b1;
                end
            end
        end else if (stop) begin
            state_d = S_IDLE;
        end else if (load) begin
            sel_d   = load_sel;
            cnt_d   = dwell_ld;
            state_d = S_DWELL;
        end else if (advance) begin
            if (!adv_found || (adv_pass7 && !cont_q)) begin
                // End of a single pass (or nothing left to visit): select holds its last value.
                wrap_d  = 1'b1;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end else begin
                sel_d   = adv_sel;
                cnt_d   = dwell_ld;
                wrap_d  = adv_pass7;
                state_d = S_DWELL;
            end
        end else if (state_q == S_DWELL) begin
            if (cnt_q > DWELL_W'(1)) begin
                cnt_d = cnt_q - DWELL_W'(1);
            end else begin
                state_d = S_HOLD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            cont_q  <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            cont_q  <= cont_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign a         = sel_q[2];
    assign b         = sel_q[1];
    assign c         = sel_q[0];
    assign sel_valid = (state_q != S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign wrap      = wrap_q;
    assign done      = done_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed self-checking bench for decoder_scan_sequencer (default build, no skip mask).
module tb_decoder_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, stop, cont, load, sel_ready;
    logic [7:0] dwell;
    logic [2:0] load_sel;
    logic       a, b, c, sel_valid, busy, wrap, done;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    decoder_scan_sequencer #(.DWELL_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .cont      (cont),
        .dwell     (dwell),
        .load      (load),
        .load_sel  (load_sel),
        .sel_ready (sel_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .sel_valid (sel_valid),
        .busy      (busy),
        .wrap      (wrap),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packs {abc, sel_valid, busy, wrap, done} for compact comparisons.
    function automatic logic [31:0] outs();
        return {25'd0, a, b, c, sel_valid, busy, wrap, done};
    endfunction

    function automatic logic [31:0] exp_outs(input logic [2:0] abc, input logic v,
                                             input logic bz, input logic w, input logic d);
        return {25'd0, abc, v, bz, w, d};
    endfunction

    initial begin
        rst = 1'b1; start = 1'b1; stop = 1'b0; cont = 1'b0; load = 1'b0;
        sel_ready = 1'b1; dwell = 8'd3; load_sel = 3'd0;

        // 1. reset wins over start
        step();
        chk("reset_c1", outs(), exp_outs(3'b000, 0, 0, 0, 0));
        step();
        chk("reset_c2", outs(), exp_outs(3'b000, 0, 0, 0, 0));
        rst = 1'b0; start = 1'b0;
        step();
        chk("idle_after_reset", outs(), exp_outs(3'b000, 0, 0, 0, 0));

        // 2. single pass, dwell=3: address k spans T(1+3k)..T(3+3k), end pulses at T25
        start = 1'b1; cont = 1'b0; dwell = 8'd3;
        step();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 3; j++) begin
                chk($sformatf("pass_k%0d_j%0d", k, j), outs(), exp_outs(3'(k), 1, 1, 0, 0));
                step();
            end
        end
        chk("pass_end_pulse", outs(), exp_outs(3'b111, 0, 0, 1, 1));
        step();
        chk("pass_end_after", outs(), exp_outs(3'b111, 0, 0, 0, 0));

        // start coincident with stop in IDLE stays IDLE
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("start_stop_idle", outs(), exp_outs(3'b111, 0, 0, 0, 0));

        // 3. backpressure: ready low for T7..T11 while abc=010
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("bp_at_010", outs(), exp_outs(3'b010, 1, 1, 0, 0));
        sel_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("bp_hold_%0d", i), outs(), exp_outs(3'b010, 1, 1, 0, 0));
            // start while busy is ignored
            start = (i == 1);
        end
        start = 1'b0;
        sel_ready = 1'b1;
        step();
        chk("bp_release", outs(), exp_outs(3'b011, 1, 1, 0, 0));
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("bp_stop", outs(), exp_outs(3'b011, 0, 0, 0, 0));

        // 4. continuous, dwell=0 acts as 1
        cont = 1'b1; dwell = 8'd0; start = 1'b1;
        step();
        start = 1'b0; cont = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            chk($sformatf("cont_i%0d", i), outs(), exp_outs(3'(i % 8), 1, 1, (i == 8), 0));
            step();
        end
        chk("cont_wrap_once", outs(), exp_outs(3'b001, 1, 1, 0, 0));
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("cont_stop", outs(), exp_outs(3'b001, 0, 0, 0, 0));

        // 5. load at abc=001 then stop
        dwell = 8'd3; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        chk("load_at_001", outs(), exp_outs(3'b001, 1, 1, 0, 0));
        load = 1'b1; load_sel = 3'd5;
        step();
        load = 1'b0;
        chk("load_101", outs(), exp_outs(3'b101, 1, 1, 0, 0));
        step(); step();
        chk("load_dwell_reload", outs(), exp_outs(3'b101, 1, 1, 0, 0));
        step();
        chk("load_then_adv", outs(), exp_outs(3'b110, 1, 1, 0, 0));
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("load_stop", outs(), exp_outs(3'b110, 0, 0, 0, 0));
        step();
        chk("load_stop_no_done", outs(), exp_outs(3'b110, 0, 0, 0, 0));

        // load coincident with the final advance wins: no wrap/done
        dwell = 8'd1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("lw_at_111", outs(), exp_outs(3'b111, 1, 1, 0, 0));
        load = 1'b1; load_sel = 3'd2;
        step();
        load = 1'b0;
        chk("lw_load_wins", outs(), exp_outs(3'b010, 1, 1, 0, 0));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("lw_reset", outs(), exp_outs(3'b000, 0, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
